prio_arbiter_4req: RTL

- Arbitrates one shared resource among 4 requesters. Grant selection uses the team's 4-to-2 priority encoder (msb = highest priority).
- Selection is either fixed priority or rotating (round-robin) priority.
- A grant is held until the owner drops its request, with an optional hold-timeout.
- Sits in front of any single-port shared datapath; downstream muxes use gnt_id as the select.

---
 rtl/arb_pkg.sv | 12 +
 rtl/priority_encoder2_4to2.sv | 16 +
 rtl/prio_arbiter_4req.sv | 111 +++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and sizes for the 4-requester arbiter
package arb_pkg;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/priority_encoder2_4to2.sv
// rtl/priority_encoder2_4to2.sv - 4-to-2 priority encoder, d[3] highest priority
module priority_encoder2_4to2 (
  input  logic [3:0] d,
  output logic [1:0] q,
  output logic       v
);

  always_comb begin
    v = |d;
    q = 2'd0;
    if (d[3])      q = 2'd3;
    else if (d[2]) q = 2'd2;
    else if (d[1]) q = 2'd1;
  end

endmodule

// File: rtl/prio_arbiter_4req.sv
// rtl/prio_arbiter_4req.sv - 4-requester fixed/round-robin arbiter with hold-until-release and optional hold timeout
module prio_arbiter_4req
  import arb_pkg::*;
#(
  parameter int unsigned RR_EN    = 1,
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id,
  output logic            gnt_valid,
  output logic            timeout
);

  localparam logic [NREQ-1:0]  ONE      = NREQ'(1);
  localparam logic [CNT_W-1:0] CNT_SAT  = '1;
  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);

  state_t           state_q, state_d;
  logic [IDW-1:0]   last_q, last_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [IDW-1:0]   gnt_id_q, gnt_id_d;
  logic             timeout_q, timeout_d;

  logic [NREQ-1:0]  masked;
  logic [IDW-1:0]   sel_masked, sel_req, sel;
  logic             masked_v, req_v;

  // Only requesters below the previous owner survive the mask, so the owner drops to lowest priority.
  assign masked = req & ((ONE << last_q) - ONE);

  priority_encoder2_4to2 u_pe_masked (
    .d (masked),
    .q (sel_masked),
    .v (masked_v)
  );

  priority_encoder2_4to2 u_pe_req (
    .d (req),
    .q (sel_req),
    .v (req_v)
  );

  always_comb begin
    sel = sel_req;
    if (RR_EN != 0 && masked_v) sel = sel_masked;
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    hold_cnt_d = hold_cnt_q;
    gnt_d      = gnt_q;
    gnt_id_d   = gnt_id_q;
    timeout_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_v) begin
          gnt_d      = ONE << sel;
          gnt_id_d   = sel;
          hold_cnt_d = CNT_W'(1);
          last_d     = sel;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        if (!req[gnt_id_q]) begin
          gnt_d      = '0;
          hold_cnt_d = '0;
          state_d    = IDLE;
        end else if (MAX_HOLD != 0 && hold_cnt_q == HOLD_LIM) begin
          gnt_d      = '0;
          hold_cnt_d = '0;
          timeout_d  = 1'b1;
          state_d    = IDLE;
        end else if (hold_cnt_q != CNT_SAT) begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      last_q     <= '0;
      hold_cnt_q <= '0;
      gnt_q      <= '0;
      gnt_id_q   <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      hold_cnt_q <= hold_cnt_d;
      gnt_q      <= gnt_d;
      gnt_id_q   <= gnt_id_d;
      timeout_q  <= timeout_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = gnt_id_q;
  assign gnt_valid = |gnt_q;
  assign timeout   = timeout_q;

endmodule
